// File: rtl/timer_pkg.sv
// Shared constants for the BCD countdown timer: FSM state encodings and BCD digit limits.
// Also holds the per-digit preset saturation helper.
package timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_PAUSE = 2'd2;
    localparam state_t S_DONE  = 2'd3;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    // Clamp an out-of-range preset nibble to the largest legal BCD digit.
    function automatic logic [3:0] bcd_sat(input logic [3:0] digit);
        return (digit > BCD_MAX) ? BCD_MAX : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Combinational single-digit BCD decrement with borrow in/out.
// Chained digit by digit to form a multi-digit down-counter.
module bcd_digit_down
    import timer_pkg::*;
(
    input  logic [3:0] digit_in,
    input  logic       borrow_in,
    output logic [3:0] digit_out,
    output logic       borrow_out
);

    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        digit_out  = digit_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit_in == BCD_ZERO) begin
                digit_out  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_out = digit_in - 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: saturating preset load, start/stop control,
// one decrement per tick while running, and a one-cycle expiry pulse.
module bcd_down_timer
    import timer_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                stop,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                zero,
    output logic                expired
);

    localparam int W = 4 * DIGITS;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           running_q, running_d;
    logic           expired_q, expired_d;

    logic [W-1:0]   count_dec;
    logic [W-1:0]   load_sat;
    logic [DIGITS:0] borrow;

    assign borrow[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit_down u_digit (
            .digit_in  (count_q[4*i +: 4]),
            .borrow_in (borrow[i]),
            .digit_out (count_dec[4*i +: 4]),
            .borrow_out(borrow[i+1])
        );
        assign load_sat[4*i +: 4] = bcd_sat(load_val[4*i +: 4]);
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
        if (load) begin
            count_d = load_sat;
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (stop) begin
                        state_d = S_PAUSE;
                    // A borrow out of the top digit would mean wrapping below zero.
                    end else if (tick && !borrow[DIGITS]) begin
                        count_d = count_dec;
                        if (count_dec == '0) begin
                            state_d   = S_DONE;
                            expired_d = 1'b1;
                        end
                    end
                end
                S_IDLE, S_PAUSE: begin
                    if (start && count_q != '0) begin
                        state_d = S_RUN;
                    end
                end
                default: ;
            endcase
        end
        running_d = (state_d == S_RUN);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            count_q   <= '0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign count   = count_q;
    assign running = running_q;
    assign expired = expired_q;
    assign zero    = (count_q == '0);

endmodule
